// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl: AHB-Lite slave in front of a single-port Block RAM (1-cycle
// registered read). Decodes AHB transfers into a BRAM word address, byte-lane
// write enables and write data.
//
// Build option: BRAM_WBUF_EN
//   defined   - one-entry posted write buffer with read forwarding; every
//               transfer completes with zero wait states.
//   undefined - no buffer; a read accepted during a write data phase gets one
//               wait state.
//
// Ports
//   HCLK, HRESET         clock (also BRAM clka), async active-high reset
//   HSEL..HWDATA         AHB-Lite slave inputs
//   HREADYOUT, HRDATA    AHB-Lite slave outputs; HRESP is always OKAY
//   BRAM_ADDR/WDATA/WE   BRAM port A address, write data, byte write enables
//   BRAM_RDATA           BRAM port A read data
module ahb_bram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic [31:0]           HWDATA,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WE,
  input  logic [31:0]           BRAM_RDATA
);

  logic                  acc;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [3:0]            amask;
  logic                  wpend;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [3:0]            wmask;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  unused;

  assign acc    = HSEL & HTRANS[1] & HREADY;
  assign rd_acc = acc & ~HWRITE;
  assign wr_acc = acc & HWRITE;
  assign raddr  = HADDR[ADDR_WIDTH+1:2];
  assign HRESP  = 1'b0;
  assign unused = &{1'b0, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

  always_comb begin
    amask = 4'b1111;
    case (HSIZE)
      3'd0:    amask = 4'b0001 << HADDR[1:0];
      3'd1:    amask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: amask = 4'b1111;
    endcase
  end

  // Write address phase capture; wpend marks the following data phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wpend  <= 1'b0;
      waddr  <= '0;
      wmask  <= '0;
      addr_q <= '0;
    end else begin
      addr_q <= BRAM_ADDR;
      if (HREADY) begin
        wpend <= wr_acc;
        if (wr_acc) begin
          waddr <= raddr;
          wmask <= amask;
        end
      end
    end
  end

`ifdef BRAM_WBUF_EN
  logic                  bvalid;
  logic [ADDR_WIDTH-1:0] baddr;
  logic [3:0]            bmask;
  logic [31:0]           bdata;
  logic [3:0]            fmask;
  logic [31:0]           fdata;
  logic                  ent_valid;
  logic [ADDR_WIDTH-1:0] ent_addr;
  logic [3:0]            ent_mask;
  logic [31:0]           ent_data;
  logic                  fwd_hit;
  logic [31:0]           fsel;

  assign HREADYOUT = 1'b1;

  // Buffer entry as seen by a read this cycle, including one being loaded now.
  assign ent_valid = wpend | bvalid;
  assign ent_addr  = wpend ? waddr  : baddr;
  assign ent_mask  = wpend ? wmask  : bmask;
  assign ent_data  = wpend ? HWDATA : bdata;
  assign fwd_hit   = rd_acc & ent_valid & (ent_addr == raddr);

  always_comb begin
    BRAM_ADDR  = addr_q;
    BRAM_WE    = '0;
    BRAM_WDATA = HWDATA;
    if (rd_acc) begin
      BRAM_ADDR = raddr;
    end else if (wpend) begin
      BRAM_ADDR = waddr;
      BRAM_WE   = wmask;
    end else if (bvalid) begin
      BRAM_ADDR  = baddr;
      BRAM_WE    = bmask;
      BRAM_WDATA = bdata;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      bvalid <= 1'b0;
      baddr  <= '0;
      bmask  <= '0;
      bdata  <= '0;
      fmask  <= '0;
      fdata  <= '0;
    end else begin
      if (rd_acc && wpend) begin
        bvalid <= 1'b1;
        baddr  <= waddr;
        bmask  <= wmask;
        bdata  <= HWDATA;
      end else if (!rd_acc && !wpend && bvalid) begin
        bvalid <= 1'b0;
      end
      fmask <= fwd_hit ? ent_mask : 4'b0000;
      if (fwd_hit) fdata <= ent_data;
    end
  end

  assign fsel   = {{8{fmask[3]}}, {8{fmask[2]}}, {8{fmask[1]}}, {8{fmask[0]}}};
  assign HRDATA = (fdata & fsel) | (BRAM_RDATA & ~fsel);

  // A write's own address phase always drains the buffer before its data phase.
  a_no_stall: assert property (@(posedge HCLK) disable iff (HRESET) !(wpend && bvalid));
`else
  typedef enum logic {ST_RUN, ST_STALL} state_t;
  state_t                state;
  logic                  ready_q;
  logic [ADDR_WIDTH-1:0] raddr_q;

  assign HREADYOUT = ready_q;
  assign HRDATA    = BRAM_RDATA;

  always_comb begin
    BRAM_ADDR  = addr_q;
    BRAM_WE    = '0;
    BRAM_WDATA = HWDATA;
    if (wpend) begin
      BRAM_ADDR = waddr;
      BRAM_WE   = wmask;
    end else if (state == ST_STALL) begin
      BRAM_ADDR = raddr_q;
    end else if (rd_acc) begin
      BRAM_ADDR = raddr;
    end
  end

  // Read colliding with a write data phase is replayed from raddr_q one cycle later.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= ST_RUN;
      ready_q <= 1'b1;
      raddr_q <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (wpend && rd_acc) begin
            state   <= ST_STALL;
            ready_q <= 1'b0;
            raddr_q <= raddr;
          end
        end
        default: begin
          state   <= ST_RUN;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
`endif

endmodule
